// File: rtl/cdf_scan_sequencer.sv
// Sequences one CDF pass: scans every histogram bin, streams counts to the accumulator, captures total/min.
// Optional expected-total comparison is enabled by defining CDF_SCAN_TOTAL_CHECK_EN.
`timescale 1ns/1ps

module cdf_scan_sequencer #(
   parameter int NUM_BINS   = 256,
   parameter int BIN_ADDR_W = 8,
   parameter int DATA_W     = 20
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  hist_rd_en,
   output logic [BIN_ADDR_W-1:0] hist_rd_addr,
   input  logic [DATA_W-1:0]     hist_rd_data,
   output logic                  acc_start,
   output logic [DATA_W-1:0]     acc_data,
   output logic [15:0]           acc_addr,
   input  logic [DATA_W-1:0]     acc_result,
   input  logic [DATA_W-1:0]     acc_cdf_min,
   input  logic                  acc_cdf_valid,
`ifdef CDF_SCAN_TOTAL_CHECK_EN
   input  logic [DATA_W-1:0]     expected_total,
   output logic                  total_error,
`endif
   output logic [DATA_W-1:0]     cdf_total,
   output logic [DATA_W-1:0]     cdf_min,
   output logic                  hist_empty
);

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      FLUSH,
      DRAIN,
      DONE
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [BIN_ADDR_W-1:0]   bin_count;
   logic                    flush_count;
   logic                    rd_en_d1;
   logic [BIN_ADDR_W-1:0]   addr_d1;
   logic [BIN_ADDR_W-1:0]   addr_d2;
   logic                    min_seen;
   logic [DATA_W-1:0]       min_value;
   logic                    start_accept;
   logic                    abort_now;
   logic                    last_bin;

   assign start_accept = (state == IDLE) && start && !abort;
   assign abort_now    = abort && (state != IDLE);
   assign last_bin     = (bin_count == BIN_ADDR_W'(NUM_BINS - 1));
   assign acc_addr     = 16'(addr_d2);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next   = state;
      hist_rd_en   = 1'b0;
      hist_rd_addr = bin_count;
      busy         = 1'b0;
      done         = 1'b0;
      unique case (state)
         IDLE:  if (start_accept) state_next = SCAN;
         SCAN: begin
            hist_rd_en = 1'b1;
            busy       = 1'b1;
            if (last_bin) state_next = FLUSH;
         end
         FLUSH: begin
            busy = 1'b1;
            if (flush_count) state_next = DRAIN;
         end
         DRAIN: begin
            busy       = 1'b1;
            state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (abort_now) state_next = IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         bin_count   <= '0;
         flush_count <= 1'b0;
      end else begin
         state <= state_next;
         if (abort_now || start_accept) bin_count <= '0;
         else if (state == SCAN)        bin_count <= bin_count + 1'b1;
         flush_count <= (state == FLUSH) && !flush_count && !abort_now;
      end
   end

   // The accumulator clears whenever StartIn drops, so an abort must flush the whole feed pipeline.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_en_d1  <= 1'b0;
         acc_start <= 1'b0;
         addr_d1   <= '0;
         addr_d2   <= '0;
         acc_data  <= '0;
      end else if (abort_now) begin
         rd_en_d1  <= 1'b0;
         acc_start <= 1'b0;
         addr_d1   <= '0;
         addr_d2   <= '0;
         acc_data  <= '0;
      end else begin
         rd_en_d1  <= hist_rd_en;
         acc_start <= rd_en_d1;
         addr_d1   <= hist_rd_addr;
         addr_d2   <= addr_d1;
         acc_data  <= hist_rd_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         min_seen  <= 1'b0;
         min_value <= '0;
      end else if (start_accept) begin
         min_seen  <= 1'b0;
         min_value <= '0;
      end else if (busy && acc_cdf_valid && !min_seen) begin
         min_seen  <= 1'b1;
         min_value <= acc_cdf_min;
      end
   end

   // A lone non-zero last bin is never flagged by the accumulator; the final total is then the minimum.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cdf_total  <= '0;
         cdf_min    <= '0;
         hist_empty <= 1'b0;
      end else if ((state == DRAIN) && !abort_now) begin
         cdf_total  <= acc_result;
         hist_empty <= (acc_result == '0);
         cdf_min    <= min_seen ? min_value : acc_result;
      end
   end

`ifdef CDF_SCAN_TOTAL_CHECK_EN
   logic [DATA_W-1:0] expected_reg;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         expected_reg <= '0;
         total_error  <= 1'b0;
      end else if (start_accept) begin
         expected_reg <= expected_total;
         total_error  <= 1'b0;
      end else if ((state == DRAIN) && !abort_now) begin
         total_error  <= (acc_result != expected_reg);
      end
   end
`endif

endmodule

// File: tb/tb_cdf_scan_sequencer.sv
// Directed bench for cdf_scan_sequencer with histogram RAM and CDF accumulator models.
// Define CDF_SCAN_TOTAL_CHECK_EN to also exercise the expected-total comparison.
`timescale 1ns/1ps

module tb_cdf_scan_sequencer;

   localparam int NUM_BINS   = 256;
   localparam int BIN_ADDR_W = 8;
   localparam int DATA_W     = 20;

   logic                  clock = 1'b0;
   logic                  reset_n = 1'b0;
   logic                  start = 1'b0;
   logic                  abort = 1'b0;
   logic                  busy;
   logic                  done;
   logic                  hist_rd_en;
   logic [BIN_ADDR_W-1:0] hist_rd_addr;
   logic [DATA_W-1:0]     hist_rd_data;
   logic                  acc_start;
   logic [DATA_W-1:0]     acc_data;
   logic [15:0]           acc_addr;
   logic [DATA_W-1:0]     acc_result;
   logic [DATA_W-1:0]     acc_cdf_min;
   logic                  acc_cdf_valid;
   logic [DATA_W-1:0]     cdf_total;
   logic [DATA_W-1:0]     cdf_min;
   logic                  hist_empty;
`ifdef CDF_SCAN_TOTAL_CHECK_EN
   logic [DATA_W-1:0]     expected_total = '0;
   logic                  total_error;
`endif

   cdf_scan_sequencer #(
      .NUM_BINS  (NUM_BINS),
      .BIN_ADDR_W(BIN_ADDR_W),
      .DATA_W    (DATA_W)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .start        (start),
      .abort        (abort),
      .busy         (busy),
      .done         (done),
      .hist_rd_en   (hist_rd_en),
      .hist_rd_addr (hist_rd_addr),
      .hist_rd_data (hist_rd_data),
      .acc_start    (acc_start),
      .acc_data     (acc_data),
      .acc_addr     (acc_addr),
      .acc_result   (acc_result),
      .acc_cdf_min  (acc_cdf_min),
      .acc_cdf_valid(acc_cdf_valid),
`ifdef CDF_SCAN_TOTAL_CHECK_EN
      .expected_total(expected_total),
      .total_error  (total_error),
`endif
      .cdf_total    (cdf_total),
      .cdf_min      (cdf_min),
      .hist_empty   (hist_empty)
   );

   always #5 clock = ~clock;

   // Histogram RAM: one-cycle read latency.
   logic [DATA_W-1:0] mem [NUM_BINS];
   always @(posedge clock) begin
      if (hist_rd_en) hist_rd_data <= mem[hist_rd_addr];
   end

   // Accumulator: sums while StartIn is high, clears when it is low, flags the first non-zero running sum.
   logic acc_seen;
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acc_result    <= '0;
         acc_cdf_min   <= '0;
         acc_cdf_valid <= 1'b0;
         acc_seen      <= 1'b0;
      end else if (acc_start) begin
         acc_result    <= acc_result + acc_data;
         acc_cdf_valid <= 1'b0;
         if (!acc_seen && acc_result != '0) begin
            acc_cdf_valid <= 1'b1;
            acc_cdf_min   <= acc_result;
            acc_seen      <= 1'b1;
         end
      end else begin
         acc_result    <= '0;
         acc_cdf_valid <= 1'b0;
         acc_seen      <= 1'b0;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   int                first_on, last_on, on_cnt, addr_err, data_err;
   int                done_cyc, done_cnt, busy_cnt;
   logic [DATA_W-1:0] r_total, r_min;
   logic              r_empty;
   logic              r_terr;

   task automatic fill(input logic [DATA_W-1:0] v);
      for (int i = 0; i < NUM_BINS; i++) mem[i] = v;
   endtask

   // Start in cycle 0, then observe cycles 1..300 at the falling edge.
   task automatic run_pass(input bit poke_start);
      first_on = 0; last_on = 0; on_cnt = 0; addr_err = 0; data_err = 0;
      done_cyc = 0; done_cnt = 0; busy_cnt = 0;
      r_total = 'x; r_min = 'x; r_empty = 1'bx; r_terr = 1'bx;
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clock);
         if (poke_start && k == 50) start = 1'b1;
         if (k == 51) start = 1'b0;
         if (acc_start) begin
            on_cnt++;
            if (first_on == 0) first_on = k;
            last_on = k;
            if (k < 3 || k - 3 >= NUM_BINS) begin
               addr_err++;
            end else begin
               if (acc_addr !== 16'(k - 3)) addr_err++;
               if (acc_data !== mem[k-3])   data_err++;
            end
         end
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            done_cyc = k;
            r_total  = cdf_total;
            r_min    = cdf_min;
            r_empty  = hist_empty;
`ifdef CDF_SCAN_TOTAL_CHECK_EN
            r_terr   = total_error;
`endif
         end
      end
   endtask

   task automatic check_pass(input string name, input int total, input int min_v, input bit empty);
      check({name, ".acc_start_first"}, first_on, 3);
      check({name, ".acc_start_last"},  last_on,  NUM_BINS + 2);
      check({name, ".acc_start_count"}, on_cnt,   NUM_BINS);
      check({name, ".acc_addr_errs"},   addr_err, 0);
      check({name, ".acc_data_errs"},   data_err, 0);
      check({name, ".busy_cycles"},     busy_cnt, NUM_BINS + 3);
      check({name, ".done_count"},      done_cnt, 1);
      check({name, ".done_cycle"},      done_cyc, NUM_BINS + 4);
      check({name, ".cdf_total"},       32'(r_total), total);
      check({name, ".cdf_min"},         32'(r_min),   min_v);
      check({name, ".hist_empty"},      32'(r_empty), 32'(empty));
   endtask

   int abort_done;

   initial begin
      // Reset state
      #12;
      check("rst.busy",       32'(busy),       0);
      check("rst.done",       32'(done),       0);
      check("rst.hist_rd_en", 32'(hist_rd_en), 0);
      check("rst.acc_start",  32'(acc_start),  0);
      check("rst.acc_addr",   32'(acc_addr),   0);
      check("rst.cdf_total",  32'(cdf_total),  0);
      check("rst.cdf_min",    32'(cdf_min),    0);
      check("rst.hist_empty", 32'(hist_empty), 0);
      @(negedge clock);
      reset_n = 1'b1;

      // All bins 1, with a start pulse mid-pass that must be ignored
      fill(20'd1);
      run_pass(1'b1);
      check_pass("ones", 256, 1, 1'b0);

      // Bin 0 = 7, bin 10 = 3
      fill(20'd0);
      mem[0]  = 20'd7;
      mem[10] = 20'd3;
      run_pass(1'b0);
      check_pass("sparse", 10, 7, 1'b0);

      // Empty histogram
      fill(20'd0);
      run_pass(1'b0);
      check_pass("zeros", 0, 0, 1'b1);

      // Only the last bin non-zero: the minimum comes from the drain rule
      mem[NUM_BINS-1] = 20'd5;
      run_pass(1'b0);
      check_pass("last", 5, 5, 1'b0);

      // Abort in cycle 100, restart in cycle 105
      fill(20'd1);
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (99) @(posedge clock);
      #1 abort = 1'b1;
      @(posedge clock);
      #1 abort = 1'b0;
      @(negedge clock);
      abort_done = done ? 1 : 0;
      check("abort.acc_start",  32'(acc_start),  0);
      check("abort.hist_rd_en", 32'(hist_rd_en), 0);
      check("abort.busy",       32'(busy),       0);
      check("abort.cdf_total",  32'(cdf_total),  5);
      check("abort.cdf_min",    32'(cdf_min),    5);
      check("abort.hist_empty", 32'(hist_empty), 0);
      repeat (3) begin
         @(negedge clock);
         if (done) abort_done++;
      end
      check("abort.no_done", abort_done, 0);
      run_pass(1'b0);
      check_pass("restart", 256, 1, 1'b0);

`ifdef CDF_SCAN_TOTAL_CHECK_EN
      expected_total = 20'd255;
      run_pass(1'b0);
      check("terr.mismatch", 32'(r_terr), 1);
      expected_total = 20'd256;
      run_pass(1'b0);
      check("terr.match", 32'(r_terr), 0);
`endif

      // Reset in the middle of a pass
      fill(20'd2);
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (40) @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("midrst.busy",       32'(busy),       0);
      check("midrst.hist_rd_en", 32'(hist_rd_en), 0);
      check("midrst.acc_start",  32'(acc_start),  0);
      check("midrst.acc_data",   32'(acc_data),   0);
      check("midrst.cdf_total",  32'(cdf_total),  0);
      check("midrst.cdf_min",    32'(cdf_min),    0);
      @(negedge clock);
      reset_n = 1'b1;
      run_pass(1'b0);
      check_pass("after_rst", 512, 2, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cdf_scan_sequencer.md
Name: cdf_scan_sequencer

Overview:
Controller that sequences one cumulative-distribution pass of the histogram-equalization pipeline. On a start pulse it walks every histogram bin in order and reads it from the histogram RAM. It streams the bin counts into the CDF accumulate stage with a gap-free start window, then captures the final pixel total and the CDF minimum, and signals completion. It sits between the histogram RAM and the CDF accumulate stage, under the top-level frame controller.

Parameters:
NUM_BINS, 256, number of histogram bins scanned per pass (power of two, at least 4)
BIN_ADDR_W, 8, histogram RAM address width; NUM_BINS equals 2**BIN_ADDR_W
DATA_W, 20, width of bin counts, CDF total and CDF minimum

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a pass; sampled only in IDLE
abort  input  1  cancel the current pass; returns to IDLE with no done
busy  output  1  high from the cycle after start is accepted until done is asserted
done  output  1  one-cycle pulse; cdf_total, cdf_min and hist_empty are valid while it is high
hist_rd_en  output  1  histogram RAM read strobe
hist_rd_addr  output  BIN_ADDR_W  histogram RAM read address
hist_rd_data  input  DATA_W  RAM read data, valid 1 cycle after hist_rd_en
acc_start  output  1  drives accumulator StartIn
acc_data  output  DATA_W  drives accumulator AccumlateIn
acc_addr  output  16  drives accumulator StoreAddressIn; bin index zero-extended
acc_result  input  DATA_W  accumulator AccumlateResult
acc_cdf_min  input  DATA_W  accumulator CdfMin
acc_cdf_valid  input  1  accumulator CdfValid
cdf_total  output  DATA_W  final accumulated total, held until the next done
cdf_min  output  DATA_W  first non-zero CDF value, held until the next done
hist_empty  output  1  set when cdf_total is 0, held until the next done

Behaviour:
- Reset: asynchronous and active-low on reset_n; clock is clock. All outputs reset to 0 and the state resets to IDLE.
- States are IDLE, SCAN, FLUSH, DRAIN and DONE.
- IDLE: when start=1, go to SCAN next cycle with bin counter 0 and a cleared min-seen flag. Call the start-sample cycle cycle 0.
- SCAN (cycles 1..NUM_BINS): each cycle, hist_rd_en=1 and hist_rd_addr=counter, then the counter increments. After the last bin, go to FLUSH.
- Feed pipeline: hist_rd_data is registered into acc_data. acc_addr is the address delayed 2 cycles. acc_start is the read-enable delayed 2 cycles.
  - acc_start is high continuously in cycles 3..NUM_BINS+2.
  - acc_start must never drop inside this window, because the accumulator clears on a low StartIn.
- FLUSH: lasts 2 cycles, no reads issued, lets the pipeline empty.
- DRAIN (cycle NUM_BINS+3): acc_start is low and acc_result holds the final total.
  - Register cdf_total <= acc_result.
  - hist_empty <= (acc_result==0).
- Min capture: on the first acc_cdf_valid=1 while busy, latch acc_cdf_min into an internal min register and set min-seen. Later pulses are ignored.
  - In DRAIN, cdf_min <= internal min if min-seen.
  - Otherwise cdf_min <= acc_result. This covers a histogram whose only non-zero bin is the last one, which the accumulator never flags. It also gives 0 for an empty histogram.
- DONE (cycle NUM_BINS+4): done=1 and busy=0, then return to IDLE. For NUM_BINS=256, done is high in cycle 260.
- busy is 1 in cycles 1..NUM_BINS+3.
- start while busy: ignored, not queued.
- abort in any non-IDLE state: next cycle is IDLE.
  - hist_rd_en, acc_start and busy go to 0 next cycle.
  - The pipeline delay registers are cleared.
  - No done pulse; cdf_total, cdf_min and hist_empty keep their previous values.
  - abort has priority over start in the same cycle.
- Reset mid-pass: immediate return to IDLE with all outputs 0.
- Arithmetic: no arithmetic on data except the width-exact zero compare. Overflow of the total is the accumulator's concern. The counter wraps to 0 only on leaving SCAN.

Optional Feature:
Macro CDF_SCAN_TOTAL_CHECK_EN.
- When defined:
  - Adds input expected_total [DATA_W], sampled with start.
  - Adds output total_error [1], which is set in DRAIN when acc_result differs from expected_total, is valid with done, and is cleared at the next accepted start.
- When undefined: neither port exists and there is no extra logic.

Test Plan:
- All bins = 1, start pulse -> acc_start high cycles 3..258, done in cycle 260, cdf_total=256, cdf_min=1, hist_empty=0.
- Bin 0 = 7, bin 10 = 3, others 0 -> cdf_total=10, cdf_min=7.
- Only bin 255 = 5 -> no acc_cdf_valid during the pass; cdf_min=5 from the drain rule, cdf_total=5.
- All bins 0 -> cdf_total=0, cdf_min=0, hist_empty=1, done at cycle 260.
- Abort in cycle 100, then start again in cycle 105 -> acc_start low from cycle 101, no done for the first pass, second pass completes with correct totals.
- With CDF_SCAN_TOTAL_CHECK_EN: all bins 1 and expected_total=255 -> total_error=1 at done; expected_total=256 -> total_error=0.
